// File: rtl/nmr_seq_table.sv
// nmr_seq_table: table-driven NMR pulse sequencer.
// A DEPTH-entry step table (duration in us ticks, output pattern, last flag)
// is played num_repeat+1 times. Each step holds its pattern for
// eff(dur)*US_DIVIDER clock cycles, where eff(0) is treated as one tick.
module nmr_seq_table #(
  parameter int US_DIVIDER = 125,
  parameter int DEPTH      = 16,
  parameter int TW         = 32,
  parameter int NCH        = 4,
  parameter int RW         = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enbl,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [TW-1:0]            wr_dur,
  input  logic [NCH-1:0]           wr_out,
  input  logic                     wr_last,
  input  logic [RW-1:0]            num_repeat,
  output logic [NCH-1:0]           ch_out,
  output logic                     sync_out,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] step_idx
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (US_DIVIDER > 1) ? $clog2(US_DIVIDER) : 1;

  localparam logic [PW-1:0] PRE_RELOAD = PW'(US_DIVIDER - 1);
  localparam logic [AW-1:0] IDX_MAX    = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W    = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] ONE_T      = TW'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // A zero duration would otherwise underflow the step counter; play it as one tick.
  function automatic logic [TW-1:0] eff(input logic [TW-1:0] d);
    return (d == '0) ? ONE_T : d;
  endfunction

  // Step table storage
  logic [TW-1:0]  dur_mem  [DEPTH];
  logic [NCH-1:0] out_mem  [DEPTH];
  logic           last_mem [DEPTH];

  // Sequencer state
  state_t         state_q, state_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [TW-1:0]  cnt_q,   cnt_d;
  logic [RW-1:0]  rep_q,   rep_d;
  logic [AW-1:0]  idx_q,   idx_d;
  logic [NCH-1:0] ch_q,    ch_d;
  logic           sync_q,  sync_d;
  logic           busy_q,  busy_d;
  logic           done_q,  done_d;

  logic           wr_ok_s;
  logic           step_last_s;
  logic [AW-1:0]  next_idx_s;

  // The table is frozen while a sequence runs; out-of-range addresses are dropped.
  assign wr_ok_s     = wr_en && !busy_q && ({1'b0, wr_addr} < DEPTH_W);
  assign step_last_s = last_mem[idx_q] || (idx_q == IDX_MAX);
  assign next_idx_s  = idx_q + AW'(1);

  // Table write port; reset clears every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        dur_mem[k]  <= '0;
        out_mem[k]  <= '0;
        last_mem[k] <= 1'b0;
      end
    end else if (wr_ok_s) begin
      dur_mem[wr_addr]  <= wr_dur;
      out_mem[wr_addr]  <= wr_out;
      last_mem[wr_addr] <= wr_last;
    end
  end

  // Next-state logic: start/abort handling, prescaler, step and pass sequencing.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    idx_d   = idx_q;
    ch_d    = ch_q;
    sync_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rep_d   = num_repeat;
          idx_d   = '0;
          cnt_d   = eff(dur_mem[0]);
          presc_d = PRE_RELOAD;
          ch_d    = out_mem[0];
          sync_d  = 1'b1;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end else begin
          busy_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (abort) begin
          ch_d    = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (presc_q == '0) begin
          presc_d = PRE_RELOAD;
          if (cnt_q == ONE_T) begin
            if (!step_last_s) begin
              idx_d = next_idx_s;
              cnt_d = eff(dur_mem[next_idx_s]);
              ch_d  = out_mem[next_idx_s];
            end else if (rep_q != '0) begin
              rep_d  = rep_q - RW'(1);
              idx_d  = '0;
              cnt_d  = eff(dur_mem[0]);
              ch_d   = out_mem[0];
              sync_d = 1'b1;
            end else begin
              ch_d    = '0;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q - ONE_T;
          end
        end else begin
          presc_d = presc_q - PW'(1);
        end
      end
      default: begin
        ch_d    = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      presc_q <= PRE_RELOAD;
      cnt_q   <= '0;
      rep_q   <= '0;
      idx_q   <= '0;
      ch_q    <= '0;
      sync_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      idx_q   <= idx_d;
      ch_q    <= ch_d;
      sync_q  <= sync_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // enbl only masks the drive lines; the sequence itself keeps running.
  assign ch_out   = ch_q & {NCH{enbl}};
  assign sync_out = sync_q & enbl;
  assign busy     = busy_q;
  assign done     = done_q;
  assign step_idx = idx_q;

endmodule
